// File: rtl/tse_gxb_rx_reset_sequencer.sv
// Receive-channel bring-up sequencer for a TSE 1000BASE-X GXB lane.
// Sequences analog and digital receive resets from PLL/CDR lock, then qualifies word-alignment sync.
module tse_gxb_rx_reset_sequencer #(
    parameter int CNT_WIDTH        = 20,
    parameter int ANALOG_HOLD      = 4,
    parameter int LOCK_TIMEOUT     = 500000,
    parameter int LTD_WAIT         = 4000,
    parameter int SYNC_TIMEOUT     = 1000000,
    parameter int SYNC_LOSS_FILTER = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       rx_freqlocked,
    input  logic       rx_sync,
    output logic       rx_analogreset,
    output logic       rx_digitalreset,
    output logic       pcs_ready,
    output logic [3:0] retry_count,
    output logic       sync_lost,
    output logic [2:0] state_out
);

    typedef enum logic [2:0] {
        ANALOG_RST = 3'd0,
        WAIT_LOCK  = 3'd1,
        WAIT_LTD   = 3'd2,
        WAIT_SYNC  = 3'd3,
        READY      = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(ANALOG_HOLD - 1);
    localparam logic [CNT_WIDTH-1:0] LOCK_LAST = CNT_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] LTD_LAST  = CNT_WIDTH'(LTD_WAIT - 1);
    localparam logic [CNT_WIDTH-1:0] SYNC_LAST = CNT_WIDTH'(SYNC_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] LOSS_LAST = CNT_WIDTH'(SYNC_LOSS_FILTER - 1);

    logic [1:0] pll_sync;
    logic [1:0] lock_sync;
    logic [1:0] rxsync_sync;
    logic       pll_s;
    logic       lock_s;
    logic       sync_s;

    state_t               state;
    state_t               state_next;
    logic                 timeout;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] loss_cnt;

    // Status inputs are asynchronous to clk; two flops each before the FSM sees them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pll_sync    <= 2'b00;
            lock_sync   <= 2'b00;
            rxsync_sync <= 2'b00;
        end else begin
            pll_sync    <= {pll_sync[0], pll_locked};
            lock_sync   <= {lock_sync[0], rx_freqlocked};
            rxsync_sync <= {rxsync_sync[0], rx_sync};
        end
    end

    assign pll_s  = pll_sync[1];
    assign lock_s = lock_sync[1];
    assign sync_s = rxsync_sync[1];

    always_comb begin
        state_next = state;
        timeout    = 1'b0;
        case (state)
            ANALOG_RST: begin
                if (pll_s && (cnt >= HOLD_LAST)) begin
                    state_next = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (!pll_s) begin
                    state_next = ANALOG_RST;
                end else if (cnt == LOCK_LAST) begin
                    state_next = ANALOG_RST;
                    timeout    = 1'b1;
                end else if (lock_s) begin
                    state_next = WAIT_LTD;
                end
            end
            WAIT_LTD: begin
                if (!pll_s) begin
                    state_next = ANALOG_RST;
                end else if (!lock_s) begin
                    state_next = WAIT_LOCK;
                end else if (cnt == LTD_LAST) begin
                    state_next = WAIT_SYNC;
                end
            end
            WAIT_SYNC: begin
                if (!pll_s) begin
                    state_next = ANALOG_RST;
                end else if (!lock_s) begin
                    state_next = WAIT_LOCK;
                end else if (cnt == SYNC_LAST) begin
                    state_next = ANALOG_RST;
                    timeout    = 1'b1;
                end else if (sync_s) begin
                    state_next = READY;
                end
            end
            READY: begin
                // loss_cnt holds prior consecutive lows; this cycle's low completes the filter.
                if (!pll_s) begin
                    state_next = ANALOG_RST;
                end else if (!lock_s) begin
                    state_next = WAIT_LOCK;
                end else if (!sync_s && (loss_cnt >= LOSS_LAST)) begin
                    state_next = WAIT_SYNC;
                end
            end
            default: state_next = ANALOG_RST;
        endcase
    end

    // Outputs are decoded from state_next so they move on the same edge as the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ANALOG_RST;
            cnt             <= '0;
            loss_cnt        <= '0;
            retry_count     <= 4'd0;
            rx_analogreset  <= 1'b1;
            rx_digitalreset <= 1'b1;
            pcs_ready       <= 1'b0;
            sync_lost       <= 1'b0;
        end else begin
            state <= state_next;

            // The analog hold time only starts once the PLL is locked.
            if ((state_next != state) || ((state == ANALOG_RST) && !pll_s)) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end

            if ((state == READY) && (state_next == READY) && !sync_s) begin
                if (loss_cnt != CNT_MAX) begin
                    loss_cnt <= loss_cnt + 1'b1;
                end
            end else begin
                loss_cnt <= '0;
            end

            if (timeout && (retry_count != 4'd15)) begin
                retry_count <= retry_count + 4'd1;
            end

            rx_analogreset  <= (state_next == ANALOG_RST);
            rx_digitalreset <= (state_next == ANALOG_RST) || (state_next == WAIT_LOCK) ||
                               (state_next == WAIT_LTD);
            pcs_ready       <= (state_next == READY);
            sync_lost       <= (state == READY) && (state_next == WAIT_SYNC);
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_tse_gxb_rx_reset_sequencer.sv
// Bench for tse_gxb_rx_reset_sequencer: directed bring-up scenarios plus randomized
// lock/sync activity checked against a rule-level reference model.
module tb_tse_gxb_rx_reset_sequencer;

    localparam int AH  = 4;
    localparam int LT  = 32;
    localparam int LW  = 8;
    localparam int ST  = 40;
    localparam int SLF = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_locked = 1'b0;
    logic       rx_freqlocked = 1'b0;
    logic       rx_sync = 1'b0;
    logic       rx_analogreset;
    logic       rx_digitalreset;
    logic       pcs_ready;
    logic [3:0] retry_count;
    logic       sync_lost;
    logic [2:0] state_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: phase number, cycles spent in phase, consecutive sync lows, retries.
    int m_st, m_age, m_low, m_retry;
    bit m_lost;
    bit m_pll_h[2], m_lock_h[2], m_sync_h[2];

    tse_gxb_rx_reset_sequencer #(
        .CNT_WIDTH(8), .ANALOG_HOLD(AH), .LOCK_TIMEOUT(LT), .LTD_WAIT(LW),
        .SYNC_TIMEOUT(ST), .SYNC_LOSS_FILTER(SLF)
    ) dut (
        .clk(clk), .reset(reset), .pll_locked(pll_locked), .rx_freqlocked(rx_freqlocked),
        .rx_sync(rx_sync), .rx_analogreset(rx_analogreset), .rx_digitalreset(rx_digitalreset),
        .pcs_ready(pcs_ready), .retry_count(retry_count), .sync_lost(sync_lost),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] obs();
        return {rx_analogreset, rx_digitalreset, pcs_ready, sync_lost, state_out, retry_count};
    endfunction

    function automatic logic [11:0] model_exp();
        logic [11:0] e;
        e = {m_st == 0, m_st <= 2, m_st == 4, m_lost, 3'(m_st), 4'(m_retry)};
        return e;
    endfunction

    task automatic model_reset();
        m_st = 0; m_age = 0; m_low = 0; m_retry = 0; m_lost = 0;
        for (int i = 0; i < 2; i++) begin
            m_pll_h[i] = 0; m_lock_h[i] = 0; m_sync_h[i] = 0;
        end
    endtask

    task automatic model_step();
        bit p, l, s, to;
        int nx;
        p = m_pll_h[1]; l = m_lock_h[1]; s = m_sync_h[1];
        nx = m_st; to = 0;
        if (m_st > 4) nx = 0;
        else if (m_st == 0) begin
            if (p && m_age >= AH - 1) nx = 1;
        end else if (!p) nx = 0;
        else if (m_st >= 2 && !l) nx = 1;
        else if (m_st == 1 && m_age == LT - 1) begin nx = 0; to = 1; end
        else if (m_st == 3 && m_age == ST - 1) begin nx = 0; to = 1; end
        else if (m_st == 1 && l) nx = 2;
        else if (m_st == 2 && m_age == LW - 1) nx = 3;
        else if (m_st == 3 && s) nx = 4;
        else if (m_st == 4 && !s && m_low + 1 >= SLF) nx = 3;
        m_lost = (m_st == 4 && nx == 3);
        if (to && m_retry < 15) m_retry++;
        if (nx != m_st || (m_st == 0 && !p)) m_age = 0;
        else if (m_age < 255) m_age++;
        m_low = (m_st == 4 && nx == 4 && !s) ? m_low + 1 : 0;
        m_st = nx;
        m_pll_h[1] = m_pll_h[0];   m_pll_h[0] = pll_locked;
        m_lock_h[1] = m_lock_h[0]; m_lock_h[0] = rx_freqlocked;
        m_sync_h[1] = m_sync_h[0]; m_sync_h[0] = rx_sync;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        cyc++;
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic start(input logic p, input logic l, input logic s);
        reset = 1'b1;
        pll_locked = p; rx_freqlocked = l; rx_sync = s;
        tick(); tick();
        reset = 1'b0;
        model_reset();
        cyc = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pll_locked = 1'b1; rx_freqlocked = 1'b1; rx_sync = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (obs() !== 12'b1100_000_0000) begin
            errors++;
            $display("FAIL reset_values: got %b expected %b", obs(), 12'b1100_000_0000);
        end
    endtask

    task automatic test_nominal();
        start(1, 1, 1);
        run_to(5);
        checks++;
        if ({rx_analogreset, rx_digitalreset, state_out} !== 5'b11_000) begin
            errors++; $display("FAIL nominal_c5: got %b expected 11000", {rx_analogreset, rx_digitalreset, state_out});
        end
        run_to(6);
        checks++;
        if ({rx_analogreset, rx_digitalreset, state_out} !== 5'b01_001) begin
            errors++; $display("FAIL nominal_c6: got %b expected 01001", {rx_analogreset, rx_digitalreset, state_out});
        end
        run_to(14);
        checks++;
        if ({rx_digitalreset, state_out} !== 4'b1_010) begin
            errors++; $display("FAIL nominal_c14: got %b expected 1010", {rx_digitalreset, state_out});
        end
        run_to(15);
        checks++;
        if ({rx_digitalreset, pcs_ready, state_out} !== 5'b00_011) begin
            errors++; $display("FAIL nominal_c15: got %b expected 00011", {rx_digitalreset, pcs_ready, state_out});
        end
        run_to(16);
        checks++;
        if (obs() !== 12'b0010_100_0000) begin
            errors++; $display("FAIL nominal_c16: got %b expected %b", obs(), 12'b0010_100_0000);
        end
    endtask

    task automatic test_lock_timeout();
        int t, exp_r;
        start(1, 0, 0);
        for (int k = 1; k <= 17; k++) begin
            t = 2 + 36 * k;
            run_to(t - 1);
            exp_r = (k - 1 > 15) ? 15 : k - 1;
            checks++;
            if (state_out !== 3'd1 || retry_count !== 4'(exp_r)) begin
                errors++;
                $display("FAIL lock_timeout_pre k=%0d: state %0d retry %0d expected state 1 retry %0d",
                         k, state_out, retry_count, exp_r);
            end
            run_to(t);
            exp_r = (k > 15) ? 15 : k;
            checks++;
            if ({rx_analogreset, rx_digitalreset, state_out} !== 5'b11_000 || retry_count !== 4'(exp_r)) begin
                errors++;
                $display("FAIL lock_timeout k=%0d: state %0d retry %0d expected state 0 retry %0d",
                         k, state_out, retry_count, exp_r);
            end
        end
    endtask

    task automatic test_sync_timeout();
        start(1, 1, 0);
        run_to(54);
        checks++;
        if (state_out !== 3'd3 || retry_count !== 4'd0) begin
            errors++; $display("FAIL sync_timeout_pre: state %0d retry %0d expected 3/0", state_out, retry_count);
        end
        run_to(55);
        checks++;
        if (obs() !== 12'b1100_000_0001) begin
            errors++; $display("FAIL sync_timeout: got %b expected %b", obs(), 12'b1100_000_0001);
        end
    endtask

    task automatic test_ltd_glitch();
        start(1, 1, 1);
        run_to(10);
        rx_freqlocked = 1'b0;
        run_to(11);
        rx_freqlocked = 1'b1;
        run_to(12);
        checks++;
        if (state_out !== 3'd2) begin
            errors++; $display("FAIL ltd_glitch_c12: state %0d expected 2", state_out);
        end
        run_to(13);
        checks++;
        if ({rx_analogreset, rx_digitalreset, state_out} !== 5'b01_001) begin
            errors++; $display("FAIL ltd_glitch_c13: got %b expected 01001", {rx_analogreset, rx_digitalreset, state_out});
        end
        for (int c = 14; c <= 21; c++) begin
            run_to(c);
            checks++;
            if ({rx_digitalreset, state_out} !== 4'b1_010) begin
                errors++; $display("FAIL ltd_glitch_hold c=%0d: got %b expected 1010", c, {rx_digitalreset, state_out});
            end
        end
        run_to(22);
        checks++;
        if ({rx_digitalreset, state_out} !== 4'b0_011) begin
            errors++; $display("FAIL ltd_glitch_c22: got %b expected 0011", {rx_digitalreset, state_out});
        end
        run_to(23);
        checks++;
        if (pcs_ready !== 1'b1 || state_out !== 3'd4) begin
            errors++; $display("FAIL ltd_glitch_c23: ready %b state %0d expected 1/4", pcs_ready, state_out);
        end
    endtask

    task automatic test_sync_loss();
        start(1, 1, 1);
        run_to(20);
        rx_sync = 1'b0;
        run_to(22);
        rx_sync = 1'b1;
        for (int c = 23; c <= 29; c++) begin
            run_to(c);
            checks++;
            if ({pcs_ready, sync_lost, state_out} !== 5'b10_100) begin
                errors++; $display("FAIL sync_filter c=%0d: got %b expected 10100", c, {pcs_ready, sync_lost, state_out});
            end
        end
        run_to(30);
        rx_sync = 1'b0;
        run_to(33);
        rx_sync = 1'b1;
        run_to(34);
        checks++;
        if ({sync_lost, state_out} !== 4'b0_100) begin
            errors++; $display("FAIL sync_loss_c34: got %b expected 0100", {sync_lost, state_out});
        end
        run_to(35);
        checks++;
        if (obs() !== 12'b0001_011_0000) begin
            errors++; $display("FAIL sync_loss_c35: got %b expected %b", obs(), 12'b0001_011_0000);
        end
        run_to(36);
        checks++;
        if ({sync_lost, state_out} !== 4'b0_100) begin
            errors++; $display("FAIL sync_loss_c36: got %b expected 0100", {sync_lost, state_out});
        end
    endtask

    task automatic test_pll_drop();
        start(1, 1, 1);
        run_to(20);
        pll_locked = 1'b0;
        run_to(22);
        checks++;
        if ({rx_analogreset, rx_digitalreset, state_out} !== 5'b00_100) begin
            errors++; $display("FAIL pll_drop_c22: got %b expected 00100", {rx_analogreset, rx_digitalreset, state_out});
        end
        run_to(23);
        checks++;
        if (obs() !== 12'b1100_000_0000) begin
            errors++; $display("FAIL pll_drop_c23: got %b expected %b", obs(), 12'b1100_000_0000);
        end
    endtask

    task automatic test_async_reset();
        start(1, 1, 0);
        run_to(18);
        checks++;
        if (state_out !== 3'd3) begin
            errors++; $display("FAIL async_pre: state %0d expected 3", state_out);
        end
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (obs() !== 12'b1100_000_0000) begin
            errors++; $display("FAIL async_reset: got %b expected %b", obs(), 12'b1100_000_0000);
        end
        tick();
        rx_sync = 1'b1;
        reset = 1'b0;
        model_reset();
        cyc = 0;
        run_to(5);
        checks++;
        if (rx_analogreset !== 1'b1) begin
            errors++; $display("FAIL async_rerun_c5: analogreset %b expected 1", rx_analogreset);
        end
        run_to(6);
        checks++;
        if (rx_analogreset !== 1'b0) begin
            errors++; $display("FAIL async_rerun_c6: analogreset %b expected 0", rx_analogreset);
        end
        run_to(16);
        checks++;
        if (obs() !== 12'b0010_100_0000) begin
            errors++; $display("FAIL async_rerun_c16: got %b expected %b", obs(), 12'b0010_100_0000);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        start(1, 1, 1);
        for (int n = 0; n < 4000; n++) begin
            tick();
            checks++;
            if (obs() !== model_exp()) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random n=%0d: got %b expected %b", n, obs(), model_exp());
            end
            if (reset) reset = 1'b0;
            else if ($urandom_range(1999) == 0) reset = 1'b1;
            if (pll_locked) begin
                if ($urandom_range(299) == 0) pll_locked = 1'b0;
            end else if ($urandom_range(14) == 0) pll_locked = 1'b1;
            if (rx_freqlocked) begin
                if ($urandom_range(79) == 0) rx_freqlocked = 1'b0;
            end else if ($urandom_range(5) == 0) rx_freqlocked = 1'b1;
            if (rx_sync) begin
                if ($urandom_range(24) == 0) rx_sync = 1'b0;
            end else if ($urandom_range(3) == 0) rx_sync = 1'b1;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_nominal();
        test_lock_timeout();
        test_sync_timeout();
        test_ltd_glitch();
        test_sync_loss();
        test_pll_drop();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tse_gxb_rx_reset_sequencer.md
# tse_gxb_rx_reset_sequencer

Reset and bring-up controller for one TSE 1000BASE-X transceiver receive channel. It sequences the transceiver's analog and digital receive resets from PLL-lock and CDR-lock status. It then qualifies word-alignment sync before declaring the PCS receive path ready, and sits between the GXB receive channel and the RX sync-alignment pipeline. On loss of lock or sync it re-runs the sequence and counts bring-up retries.

## Interface
Parameters:
- CNT_WIDTH, 20, width of the shared wait/timeout counter; every count parameter below must be less than 2^CNT_WIDTH.
- ANALOG_HOLD, 4, minimum number of cycles `rx_analogreset` stays asserted.
- LOCK_TIMEOUT, 500000, cycles allowed in WAIT_LOCK for CDR lock before a retry.
- LTD_WAIT, 4000, cycles `rx_freqlocked` must stay continuously high before digital reset is released.
- SYNC_TIMEOUT, 1000000, cycles allowed in WAIT_SYNC for word alignment before a retry.
- SYNC_LOSS_FILTER, 3, consecutive low `rx_sync` cycles in READY that count as loss of sync (minimum 1).

Ports:
- clk, in, 1, receive-domain clock.
- reset, in, 1, asynchronous, active-high.
- pll_locked, in, 1, transmit/receive PLL lock; asynchronous to clk.
- rx_freqlocked, in, 1, CDR lock-to-data indication; asynchronous to clk.
- rx_sync, in, 1, word-aligner sync status (alt_sync).
- rx_analogreset, out, 1, GXB receive analog reset.
- rx_digitalreset, out, 1, GXB receive PCS digital reset; also holds the alignment pipeline in reset.
- pcs_ready, out, 1, high only in READY.
- retry_count, out, 4, number of bring-up retries; saturates at 15.
- sync_lost, out, 1, one-cycle pulse on the READY→WAIT_SYNC transition.
- state_out, out, 3, current state encoding for debug.

## Operation
- All three status inputs pass through 2-flop synchronizers. The FSM uses the synchronized versions `pll_s`, `lock_s` and `sync_s`.
- State encoding: ANALOG_RST=0, WAIT_LOCK=1, WAIT_LTD=2, WAIT_SYNC=3, READY=4. Values 5-7 are illegal and go to ANALOG_RST on the next cycle.
- Counter: cleared on every state change; increments by 1 each cycle otherwise; never wraps; holds at its maximum.
- ANALOG_RST drives analogreset=1 and digitalreset=1. Exit to WAIT_LOCK when cnt ≥ ANALOG_HOLD−1 and pll_s=1. While pll_s=0 the FSM stays in ANALOG_RST.
- WAIT_LOCK drives analogreset=0 and digitalreset=1.
  - lock_s=1 → WAIT_LTD.
  - cnt = LOCK_TIMEOUT−1 → ANALOG_RST and retry_count++.
- WAIT_LTD drives analogreset=0 and digitalreset=1.
  - lock_s=0 → WAIT_LOCK (no retry increment).
  - cnt = LTD_WAIT−1 → WAIT_SYNC.
- WAIT_SYNC drives both resets to 0.
  - sync_s=1 → READY.
  - cnt = SYNC_TIMEOUT−1 → ANALOG_RST and retry_count++.
- READY drives both resets to 0 and pcs_ready=1.
  - A separate loss counter counts consecutive sync_s=0 cycles and clears whenever sync_s=1.
  - When the loss counter reaches SYNC_LOSS_FILTER → WAIT_SYNC and sync_lost pulses.
- Priority, highest first, applied in every state except ANALOG_RST:
  1. pll_s=0 → ANALOG_RST (no retry increment).
  2. lock_s=0 in WAIT_SYNC or READY → WAIT_LOCK.
  3. Timeout.
  4. Normal advance.
- retry_count clears only on reset. It increments only on the two timeout transitions and saturates at 15.

## Timing
- Reset values: rx_analogreset=1, rx_digitalreset=1, pcs_ready=0, retry_count=0, sync_lost=0, state_out=0, all counters 0, synchronizers 0.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state register.
- Input-to-FSM latency is 2 cycles; an input change affects the outputs at the 3rd rising edge after it.
- Minimum bring-up with all inputs high from reset release is ANALOG_HOLD + 1 + LTD_WAIT + 1 cycles to READY, plus synchronizer latency.
- rx_analogreset is never deasserted while rx_digitalreset is already deasserted. Any path into ANALOG_RST reasserts both resets in the same cycle.
- Asynchronous reset mid-sequence returns to ANALOG_RST immediately, without waiting for a clock edge.

## Test plan
- Nominal bring-up (ANALOG_HOLD=4, LTD_WAIT=8, all inputs high at reset release) -> analogreset falls at cycle 6, digitalreset falls at cycle 15, pcs_ready=1 at cycle 16, retry_count=0.
- CDR lock never arrives (LOCK_TIMEOUT=32, rx_freqlocked=0) -> FSM returns to ANALOG_RST every 32+4 cycles; retry_count reads 1, 2, …, then stays at 15 after the 15th timeout.
- rx_freqlocked glitches low for 1 cycle at cnt=5 in WAIT_LTD -> FSM enters WAIT_LOCK; the LTD count restarts at 0; digitalreset stays 1 throughout.
- In READY, rx_sync low for 2 cycles then high, with SYNC_LOSS_FILTER=3 -> no transition and no sync_lost. rx_sync low for 3 cycles -> one sync_lost pulse, state_out=3, pcs_ready=0, resets remain 0.
- pll_locked drops while in READY -> both resets are 1 three edges later, state_out=0, retry_count unchanged.
- Asynchronous reset asserted mid-WAIT_SYNC, between clock edges -> outputs return to their reset values immediately, then a full sequence repeats after release.
